serial_tx_ctrl: RTL and testbench

Parallel-to-serial transmit controller built around a parallel-load shift chain. It accepts a `bit_size`-bit word on a valid/ready handshake and loads it into the chain. It then sequences the shift so the word leaves MSB first, one bit per accepted cycle, on a valid/ready serial port. It sits between a word-wide producer and any bit-serial consumer, and back-to-back words stream with no idle bubble.

---
 rtl/serial_tx_pkg.sv | 17 +
 rtl/piso_shift_reg.sv | 39 +++
 rtl/serial_tx_ctrl.sv | 83 ++++++++
 tb/tb_serial_tx_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and helpers for the serial transmit controller
package serial_tx_pkg;

  // Controller states: waiting for a word, or streaming one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  localparam int DEFAULT_BIT_SIZE = 8;

  // Width of a counter that indexes bits 0..bit_size-1 of a word.
  function automatic int cnt_width(input int bit_size);
    return (bit_size < 2) ? 1 : $clog2(bit_size);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, zero-fill left shift register
module piso_shift_reg
  import serial_tx_pkg::*;
#(
  parameter int bit_size = DEFAULT_BIT_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift_en,
  input  logic [bit_size-1:0] d,
  output logic [bit_size-1:0] q
);

  logic [bit_size-1:0] sreg_q;
  logic [bit_size-1:0] sreg_d;

  // Next value: a load wins over a shift; shifting moves toward the MSB and fills with 0.
  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = d;
    end else if (shift_en) begin
      sreg_d = {sreg_q[bit_size-2:0], 1'b0};
    end
  end

  // Chain storage, cleared asynchronously so a reset discards any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q = sreg_q;

endmodule

// File: rtl/serial_tx_ctrl.sv
// rtl/serial_tx_ctrl.sv - word-in, bit-out transmit controller, MSB first
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int bit_size = DEFAULT_BIT_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bit_size-1:0] in_data,
  output logic                sout,
  output logic                sout_valid,
  input  logic                sout_ready,
  output logic                sout_last,
  output logic                busy
);

  localparam int CNT_W = cnt_width(bit_size);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(bit_size - 1);

  tx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [bit_size-1:0] sreg;
  logic                load;
  logic                shift_en;
  logic                accept;

  piso_shift_reg #(
    .bit_size (bit_size)
  ) u_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .d        (in_data),
    .q        (sreg)
  );

  // Output decode: the chain MSB is the bit on the wire; a new word may enter
  // while idle or on the very edge the last bit is taken.
  always_comb begin
    sout       = sreg[bit_size-1];
    sout_valid = (state_q == SHIFT);
    busy       = (state_q == SHIFT);
    sout_last  = sout_valid && (cnt_q == LAST_IDX);
    in_ready   = (state_q == IDLE) || (sout_last && sout_ready);
    accept     = in_valid && in_ready;
  end

  // Sequencing: load on accept, advance one bit per consumed cycle, fall back
  // to idle after the last bit if no follow-on word is waiting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    if (accept) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if ((state_q == SHIFT) && sout_ready) begin
      if (!sout_last) begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and bit counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb/tb_serial_tx_ctrl.sv - scoreboard bench for serial_tx_ctrl
module tb_serial_tx_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         sout_last;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic fire = 1'b0;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  exp_bit_t exp_q[$];

  serial_tx_ctrl #(.bit_size(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the wire carries the bits of each accepted word, MSB first,
  // and a new word is takeable only when nothing is left or the final bit leaves now.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      check("rst_sout_valid", sout_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
    end else begin
      exp_valid = (exp_q.size() > 0);
      exp_rdy   = !exp_valid || (exp_q.size() == 1 && sout_ready);
      check("sout_valid", sout_valid, exp_valid);
      check("busy", busy, exp_valid);
      check("in_ready", in_ready, exp_rdy);
      if (exp_valid) begin
        check("sout", sout, exp_q[0].b);
        check("sout_last", sout_last, exp_q[0].last);
        if (sout_ready) void'(exp_q.pop_front());
      end else begin
        check("sout_last_idle", sout_last, 1'b0);
      end
      if (in_valid && exp_rdy) begin
        for (int i = W - 1; i >= 0; i--) begin
          exp_bit_t e;
          e.b    = in_data[i];
          e.last = (i == 0);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    fire = in_valid && in_ready && rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer a word and wait for it to be taken; in_valid is left high for the caller.
  task automatic send_word(input logic [W-1:0] d, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    do begin
      step();
      waited++;
    end while (!fire && waited < 100);
    if (!fire) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %0h not accepted after %0d cycles", d, waited);
    end
  endtask

  initial begin
    int w;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    sout_ready = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_sout_valid", sout_valid, 1'b0);
    check("reset_sout", sout, 1'b0);
    check("reset_sout_last", sout_last, 1'b0);
    check("reset_busy", busy, 1'b0);
    steps(2);
    rst_n = 1'b1;
    step();

    // Single word
    send_word(8'hA5, w);
    in_valid = 1'b0;
    steps(8);
    check("single_idle_in_ready", in_ready, 1'b1);
    check("single_idle_valid", sout_valid, 1'b0);

    // Back-to-back: second word taken on the first word's last bit
    send_word(8'hA5, w);
    send_word(8'h3C, w);
    check("b2b_wait", w, 8);
    in_valid = 1'b0;
    steps(8);

    // Backpressure on bit 3
    send_word(8'hF0, w);
    in_valid = 1'b0;
    steps(3);
    sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_sout", sout, 1'b1);
      check("stall_valid", sout_valid, 1'b1);
      step();
    end
    sout_ready = 1'b1;
    steps(5);
    check("bp_done_idle", sout_valid, 1'b0);

    // Blocked producer offering during bit 2
    send_word(8'hFF, w);
    in_valid = 1'b0;
    steps(2);
    check("blocked_in_ready", in_ready, 1'b0);
    send_word(8'h55, w);
    check("blocked_wait", w, 6);
    in_valid = 1'b0;
    steps(8);

    // Reset during bit 4
    send_word(8'h81, w);
    in_valid = 1'b0;
    steps(4);
    check("pre_reset_valid", sout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", sout_valid, 1'b0);
    check("async_rst_sout", sout, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    steps(2);
    rst_n = 1'b1;
    step();
    send_word(8'h18, w);
    check("post_reset_wait", w, 1);
    in_valid = 1'b0;
    steps(8);

    // Stall on the last bit while a new word waits
    send_word(8'h5A, w);
    in_valid = 1'b0;
    steps(7);
    check("lastbit_present", sout_last, 1'b1);
    sout_ready = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lastbit_no_accept", fire, 1'b0);
      check("lastbit_hold", sout_last, 1'b1);
    end
    sout_ready = 1'b1;
    step();
    check("lastbit_accept", fire, 1'b1);
    in_valid = 1'b0;
    steps(8);

    // Random traffic with random backpressure
    fire = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sout_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = W'($urandom);
      end
      step();
    end
    in_valid   = 1'b0;
    sout_ready = 1'b1;
    steps(20);
    check("drain_idle", sout_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
